// File: rtl/sdp_rd_stream_pkg.sv
// Shared types and defaults for the SDP RAM port-B read streamer.
package sdp_rd_stream_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_e;

    localparam int unsigned RD_LAT_DEFAULT = 2;
    localparam int unsigned DW_DEFAULT     = 4;

    // Buffer entry layout at the default data width; the FIFO packs {last, data} the same way.
    typedef struct packed {
        logic                  last;
        logic [DW_DEFAULT-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sdp_rd_stream_fifo.sv
// Small synchronous FIFO holding {last, data} entries; head is read straight from flops.
module sdp_rd_stream_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [DW-1:0] head_data,
    output logic          head_last
);

    logic [DW:0]   mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= {push_last, push_data};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop) count_q <= count_q + CW'(1);
            else if (!do_push && do_pop) count_q <= count_q - CW'(1);
        end
    end

    assign count                  = count_q;
    assign {head_last, head_data} = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && !do_push)) else $error("sdp_rd_stream_fifo: push while full");
    end

endmodule

// File: rtl/sdp_ram_rd_streamer.sv
// Read-side streamer for the narrow port B of the asymmetric SDP RAM.
// Define SDP_RD_STREAM_CNT_EN to add the beat_cnt / cmd_cnt statistics outputs.
module sdp_ram_rd_streamer
    import sdp_rd_stream_pkg::*;
#(
    parameter int unsigned AW         = 10,
    parameter int unsigned DW         = 4,
    parameter int unsigned RD_LAT     = RD_LAT_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW:0]   cmd_len,
    output logic          ram_reb,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_doutb,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          busy,
`ifdef SDP_RD_STREAM_CNT_EN
    output logic [31:0]   beat_cnt,
    output logic [15:0]   cmd_cnt,
`endif
    output logic          done
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q;
    logic [AW:0]       rem_q;
    logic [RD_LAT-1:0] pipe_vld_q, pipe_last_q;
    logic              done_q, done_set;
    logic [CW-1:0]     fifo_count;
    logic              accept, pop, issue, credit_ok, finish;
    int unsigned       inflight;

    assign accept = cmd_valid && cmd_ready;
    assign pop    = m_valid && m_ready;

    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < RD_LAT; i++) inflight += 32'(pipe_vld_q[i]);
    end

    // Every read in flight already owns a FIFO slot, so the buffer can never overflow.
    assign credit_ok = (inflight + 32'(fifo_count)) < (FIFO_DEPTH + 32'(pop));
    assign issue     = !rst && (state_q == StIssue) && (rem_q != '0) && credit_ok;
    assign finish    = (state_q == StDrain) && (inflight == 0) && (32'(fifo_count) == 32'(pop));
    assign done_set  = (accept && (cmd_len == '0)) || finish;

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && (cmd_len != '0)) state_d = StIssue;
            StIssue: if (issue && (rem_q == (AW+1)'(1))) state_d = StDrain;
            StDrain: if (finish) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = !rst && (state_q == StIdle);
        busy      = !rst && (state_q != StIdle);
        ram_reb   = issue;
        ram_addrb = addr_q;
        m_valid   = (fifo_count != '0);
        done      = done_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            rem_q       <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= done_set;
            if (accept) begin
                addr_q <= cmd_addr;
                rem_q  <= cmd_len;
            end else if (issue) begin
                addr_q <= addr_q + AW'(1);
                rem_q  <= rem_q - (AW+1)'(1);
            end
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue && (rem_q == (AW+1)'(1));
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
        end
    end

    sdp_rd_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_vld_q[RD_LAT-1]),
        .push_data (ram_doutb),
        .push_last (pipe_last_q[RD_LAT-1]),
        .pop       (pop),
        .count     (fifo_count),
        .head_data (m_data),
        .head_last (m_last)
    );

`ifdef SDP_RD_STREAM_CNT_EN
    logic [31:0] beat_cnt_q;
    logic [15:0] cmd_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            cmd_cnt_q  <= '0;
        end else begin
            if (pop && (beat_cnt_q != '1)) beat_cnt_q <= beat_cnt_q + 32'd1;
            if (done_set) cmd_cnt_q <= cmd_cnt_q + 16'd1;
        end
    end

    assign beat_cnt = beat_cnt_q;
    assign cmd_cnt  = cmd_cnt_q;
`endif

endmodule

// File: tb/tb_sdp_ram_rd_streamer.sv
// Directed bench for sdp_ram_rd_streamer with a 2-cycle RAM model holding value = addr[3:0].
// Counter checks are compiled in when SDP_RD_STREAM_CNT_EN is defined.
module tb_sdp_ram_rd_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_addr;
    logic [10:0] cmd_len;
    logic        ram_reb;
    logic [9:0]  ram_addrb;
    logic [3:0]  ram_doutb = '0;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_data;
    logic        m_last;
    logic        busy;
    logic        done;
`ifdef SDP_RD_STREAM_CNT_EN
    logic [31:0] beat_cnt;
    logic [15:0] cmd_cnt;
`endif

    int checks = 0;
    int errors = 0;

    sdp_ram_rd_streamer #(
        .AW         (10),
        .DW         (4),
        .RD_LAT     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ram_reb   (ram_reb),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
`ifdef SDP_RD_STREAM_CNT_EN
        .beat_cnt  (beat_cnt),
        .cmd_cnt   (cmd_cnt),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    // RAM port B: address register, then registered read.
    logic       ram_en_q = 1'b0;
    logic [9:0] ram_a_q  = '0;
    always @(posedge clk) begin
        ram_en_q <= ram_reb;
        ram_a_q  <= ram_addrb;
        if (ram_en_q) ram_doutb <= ram_a_q[3:0];
    end

    int         cyc = 0;
    logic [9:0] rd_q[$];
    logic [4:0] beat_q[$];
    int         first_vld_cyc = -1;
    int         first_beat_cyc = -1;
    int         last_cyc = -1;
    int         done_cyc = -1;
    int         done_cnt = 0;
    int         max_cnt = 0;
    bit         stall_prev = 1'b0;
    logic [4:0] stall_val = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", {26'd0, m_valid, m_last, m_data}, {26'd0, 1'b1, stall_val});
            stall_prev = m_valid && !m_ready;
            stall_val  = {m_last, m_data};
            if (ram_reb) rd_q.push_back(ram_addrb);
            if (m_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (m_valid && m_ready) begin
                beat_q.push_back({m_last, m_data});
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                if (m_last) last_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (32'(dut.fifo_count) > max_cnt) max_cnt = 32'(dut.fifo_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_q.delete();
        beat_q.delete();
        first_vld_cyc  = -1;
        first_beat_cyc = -1;
        last_cyc       = -1;
        done_cyc       = -1;
        max_cnt        = 0;
    endtask

    int accept_cyc;

    task automatic run_cmd(input logic [9:0] a, input logic [10:0] l, input bit bp, input int limit);
        int d0;
        int phase;
        clear_mon();
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        d0        = done_cnt;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        tick();
        accept_cyc = cyc;
        cmd_valid  = 1'b0;
        cmd_addr   = 10'h155;
        cmd_len    = 11'd7;
        if (l != 0) begin
            check("busy_after_accept", {31'd0, busy}, 32'd1);
            check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        end
        phase = 0;
        for (int i = 0; i < limit && done_cnt == d0; i++) begin
            if (bp) begin
                m_ready = (phase == 0);
                phase   = (phase + 1) % 3;
            end
            tick();
        end
        check("done_seen", done_cnt - d0, 32'd1);
        m_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic verify(input string tag, input logic [9:0] a, input int l);
        int         bad_b;
        int         bad_r;
        logic [9:0] ea;
        bad_b = 0;
        bad_r = 0;
        check({tag, "_nbeats"}, beat_q.size(), l);
        check({tag, "_nreads"}, rd_q.size(), l);
        foreach (beat_q[i]) begin
            ea = a + 10'(i);
            if (beat_q[i] !== {(i == l - 1), ea[3:0]}) bad_b++;
        end
        foreach (rd_q[i]) if (rd_q[i] !== a + 10'(i)) bad_r++;
        check({tag, "_bad_beats"}, bad_b, 0);
        check({tag, "_bad_reads"}, bad_r, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        m_ready   = 1'b1;
        tick();
        tick();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_outputs", {26'd0, ram_reb, m_valid, m_last, busy, done, 1'b0}, 32'd0);
        check("rst_addrb", {22'd0, ram_addrb}, 32'd0);
        check("rst_mdata", {28'd0, m_data}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Basic: addr 5, len 4 -> 5,6,7,8 with last on 8.
        run_cmd(10'd5, 11'd4, 1'b0, 50);
        verify("basic", 10'd5, 4);
        check("basic_beat0", {27'd0, beat_q[0]}, 32'h05);
        check("basic_beat3", {27'd0, beat_q[3]}, 32'h18);
        check("basic_first_valid_lat", first_vld_cyc - accept_cyc, 32'd3);
        check("basic_done_lat", done_cyc - last_cyc, 32'd1);
        check("basic_idle_busy", {31'd0, busy}, 32'd0);

        // Address wrap at the top of the RAM.
        run_cmd(10'd1022, 11'd4, 1'b0, 50);
        verify("wrap", 10'd1022, 4);
        check("wrap_read2", {22'd0, rd_q[2]}, 32'd0);
        check("wrap_beat1", {27'd0, beat_q[1]}, 32'h0F);

        // Backpressure: m_ready one cycle on, two off.
        run_cmd(10'd32, 11'd16, 1'b1, 200);
        verify("bp", 10'd32, 16);
        check("bp_max_fill_le4", {31'd0, (max_cnt <= 4)}, 32'd1);

        // Zero-length command: no reads, no beats, done the cycle after acceptance.
        run_cmd(10'd9, 11'd0, 1'b0, 20);
        check("len0_reads", rd_q.size(), 32'd0);
        check("len0_beats", beat_q.size(), 32'd0);
        check("len0_no_valid", first_vld_cyc, 32'hFFFF_FFFF);
        check("len0_done_cycle", done_cyc - accept_cyc, 32'd0);

        // Full address space at full throughput.
        run_cmd(10'd0, 11'd1024, 1'b0, 1200);
        verify("full", 10'd0, 1024);
        check("full_throughput", last_cyc - first_beat_cyc, 32'd1023);
        check("full_last_beat", {27'd0, beat_q[1023]}, 32'h1F);

        // Reset after three of ten beats.
        clear_mon();
        cmd_addr  = 10'd100;
        cmd_len   = 11'd10;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 50 && beat_q.size() < 3; i++) tick();
        check("midrst_three_beats", beat_q.size(), 32'd3);
        rst = 1'b1;
        tick();
        check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("midrst_outputs", {26'd0, ram_reb, m_valid, m_last, busy, done, 1'b0}, 32'd0);
        check("midrst_addrb", {22'd0, ram_addrb}, 32'd0);
        check("midrst_mdata", {28'd0, m_data}, 32'd0);
        rst = 1'b0;
        repeat (6) tick();
        check("midrst_no_stray_beats", beat_q.size(), 32'd3);
        check("midrst_beats", {17'd0, beat_q[0], beat_q[1], beat_q[2]}, {17'd0, 5'h04, 5'h05, 5'h06});
        check("midrst_no_valid", {31'd0, m_valid}, 32'd0);
        run_cmd(10'd200, 11'd2, 1'b0, 50);
        verify("after_rst", 10'd200, 2);
        check("after_rst_beats", {22'd0, beat_q[0], beat_q[1]}, {22'd0, 5'h08, 5'h19});

`ifdef SDP_RD_STREAM_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("cnt_rst_beat", beat_cnt, 32'd0);
        check("cnt_rst_cmd", {16'd0, cmd_cnt}, 32'd0);
        run_cmd(10'd40, 11'd3, 1'b0, 50);
        run_cmd(10'd60, 11'd5, 1'b0, 50);
        check("cnt_beat", beat_cnt, 32'd8);
        check("cnt_cmd", {16'd0, cmd_cnt}, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
